// File: rtl/cbm2_bus_pkg.sv
// Shared types and seg 15 memory-map constants for the CBM-II system bus arbiter.
package cbm2_bus_pkg;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_ROM  = 2'd1,
    RGN_IO   = 2'd2,
    RGN_OPEN = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_t;

  localparam int unsigned SysSeg      = 15;
  localparam logic [15:0] RomLoBase   = 16'h8000;
  localparam logic [15:0] RomLoLast   = 16'hCFFF;
  localparam logic [15:0] VidRamBase  = 16'hD000;
  localparam logic [15:0] ColRamBase  = 16'hD400;
  localparam logic [15:0] IoBase      = 16'hD800;
  localparam logic [15:0] RomHiBase   = 16'hE000;

  // Accesses that complete without touching the memory port.
  function automatic logic skips_memory(region_t rgn, logic we);
    return (rgn == RGN_OPEN) || ((rgn == RGN_ROM) && we);
  endfunction

endpackage

// File: rtl/cbm2_seg_decode.sv
// Combinational segment/model decode of a system address into a region_t.
module cbm2_seg_decode
  import cbm2_bus_pkg::*;
#(
  parameter int unsigned SEG_W = 8
) (
  input  logic             model_i,
  input  logic [1:0]       ram_size_i,
  input  logic             ipc_ram_en_i,
  input  logic [SEG_W-1:0] seg_i,
  input  logic [15:0]      addr_i,
  output region_t          region_o
);

  logic ram_prof;
  logic ram_bus;

  always_comb begin
    region_o = RGN_OPEN;
    ram_prof = 1'b0;
    ram_bus  = 1'b0;
    if (seg_i == SEG_W'(SysSeg)) begin
      if (addr_i[15:12] == 4'h0) begin
        // Upper half of $0xxx is the IPC RAM window.
        region_o = (!addr_i[11] || ipc_ram_en_i) ? RGN_RAM : RGN_OPEN;
      end else if ((addr_i >= RomLoBase && addr_i <= RomLoLast) || addr_i >= RomHiBase) begin
        region_o = RGN_ROM;
      end else if (addr_i >= VidRamBase && addr_i < ColRamBase) begin
        region_o = RGN_RAM;
      end else if (addr_i >= ColRamBase && addr_i < IoBase) begin
        region_o = model_i ? RGN_OPEN : RGN_RAM;
      end else if (addr_i >= IoBase) begin
        region_o = RGN_IO;
      end
    end else begin
      unique case (ram_size_i)
        2'd0: begin
          ram_prof = (seg_i <= SEG_W'(1));
          ram_bus  = (seg_i >= SEG_W'(1)) && (seg_i <= SEG_W'(2));
        end
        2'd1: begin
          ram_prof = (seg_i <= SEG_W'(3));
          ram_bus  = (seg_i >= SEG_W'(1)) && (seg_i <= SEG_W'(4));
        end
        default: begin
          ram_prof = 1'b1;
          ram_bus  = 1'b1;
        end
      endcase
      if (model_i ? ram_bus : ram_prof) region_o = RGN_RAM;
    end
  end

endmodule

// File: rtl/cbm2_bus_arbiter.sv
// Multi-master arbiter serialising requesters onto one system memory port, with
// fixed-priority video (master 0), round-robin for the rest and per-master read latches.
module cbm2_bus_arbiter
  import cbm2_bus_pkg::*;
#(
  parameter int unsigned       MASTERS   = 3,
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       SEG_W     = 8,
  parameter logic [DATA_W-1:0] OPEN_DATA = {DATA_W{1'b1}}
) (
  input  logic                        clk_sys_i,
  input  logic                        reset_n_i,
  input  logic                        model_i,
  input  logic [1:0]                  ram_size_i,
  input  logic                        ipc_ram_en_i,
  input  logic [MASTERS-1:0]          m_req_i,
  input  logic [MASTERS-1:0]          m_we_i,
  input  logic [MASTERS*SEG_W-1:0]    m_seg_i,
  input  logic [MASTERS*16-1:0]       m_addr_i,
  input  logic [MASTERS*DATA_W-1:0]   m_wdata_i,
  output logic [MASTERS-1:0]          m_ack_o,
  output logic [MASTERS*DATA_W-1:0]   m_rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [SEG_W+16-1:0]         mem_addr_o,
  output region_t                     mem_region_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_ack_i,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int unsigned IdxW  = $clog2(MASTERS);
  localparam int unsigned AddrW = SEG_W + 16;

  logic [SEG_W-1:0]  seg_arr   [MASTERS];
  logic [15:0]       addr_arr  [MASTERS];
  logic [DATA_W-1:0] wdata_arr [MASTERS];
  logic [DATA_W-1:0] rdata_q   [MASTERS];

  state_t            state_q;
  logic [IdxW-1:0]   rr_q;
  logic [IdxW-1:0]   win_q;
  logic              cmd_we_q;
  logic [AddrW-1:0]  cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  region_t           region_q;
  logic              mem_req_q;
  logic [MASTERS-1:0] m_ack_q;

  logic              win_valid;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   cand;
  region_t           win_region;

  always_comb begin
    for (int unsigned i = 0; i < MASTERS; i++) begin
      seg_arr[i]                    = m_seg_i[i*SEG_W +: SEG_W];
      addr_arr[i]                   = m_addr_i[i*16 +: 16];
      wdata_arr[i]                  = m_wdata_i[i*DATA_W +: DATA_W];
      m_rdata_o[i*DATA_W +: DATA_W] = rdata_q[i];
    end
  end

  // rr_q is the first master (1..MASTERS-1) to consider when video is not requesting.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (m_req_i[0]) begin
      win_valid = 1'b1;
    end else begin
      for (int unsigned k = 0; k < MASTERS - 1; k++) begin
        cand = IdxW'((32'(rr_q) - 32'd1 + k) % (MASTERS - 1) + 1);
        if (!win_valid && m_req_i[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  cbm2_seg_decode #(
    .SEG_W (SEG_W)
  ) u_seg_decode (
    .model_i      (model_i),
    .ram_size_i   (ram_size_i),
    .ipc_ram_en_i (ipc_ram_en_i),
    .seg_i        (seg_arr[win_idx]),
    .addr_i       (addr_arr[win_idx]),
    .region_o     (win_region)
  );

  always_ff @(posedge clk_sys_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= StIdle;
      rr_q        <= IdxW'(1);
      win_q       <= '0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      region_q    <= RGN_OPEN;
      mem_req_q   <= 1'b0;
      m_ack_q     <= '0;
      for (int unsigned i = 0; i < MASTERS; i++) rdata_q[i] <= '0;
    end else begin
      m_ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          // Skip arbitration during an ack pulse so the acked request is not replayed.
          if (win_valid && (m_ack_q == '0)) begin
            win_q       <= win_idx;
            cmd_we_q    <= m_we_i[win_idx];
            cmd_addr_q  <= {seg_arr[win_idx], addr_arr[win_idx]};
            cmd_wdata_q <= wdata_arr[win_idx];
            region_q    <= win_region;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          if (skips_memory(region_q, cmd_we_q)) begin
            state_q <= StDone;
          end else begin
            mem_req_q <= 1'b1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (!cmd_we_q) rdata_q[win_q] <= mem_rdata_i;
            state_q <= StDone;
          end
        end
        StDone: begin
          m_ack_q[win_q] <= 1'b1;
          if (!cmd_we_q && region_q == RGN_OPEN) rdata_q[win_q] <= OPEN_DATA;
          if (win_q != '0) begin
            rr_q <= (win_q == IdxW'(MASTERS - 1)) ? IdxW'(1) : win_q + IdxW'(1);
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_ack_o      = m_ack_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = cmd_we_q;
  assign mem_addr_o   = cmd_addr_q;
  assign mem_region_o = region_q;
  assign mem_wdata_o  = cmd_wdata_q;

endmodule

// File: tb/tb_cbm2_bus_arbiter.sv
// Scoreboard bench for cbm2_bus_arbiter: directed transfers push expectations, a monitor
// pops and compares on every m_ack pulse.
module tb_cbm2_bus_arbiter;
  import cbm2_bus_pkg::*;

  localparam int unsigned M = 3;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           model;
  logic [1:0]     ram_size;
  logic           ipc;
  logic [M-1:0]   m_req;
  logic [M-1:0]   m_we;
  logic [M*8-1:0] m_seg;
  logic [M*16-1:0] m_addr;
  logic [M*8-1:0] m_wdata;
  logic [M-1:0]   m_ack;
  logic [M*8-1:0] m_rdata;
  logic           mem_req;
  logic           mem_we;
  logic [23:0]    mem_addr;
  region_t        mem_region;
  logic [7:0]     mem_wdata;
  logic           mem_ack;
  logic [7:0]     mem_rdata;

  always #5 clk = ~clk;

  cbm2_bus_arbiter #(
    .MASTERS   (M),
    .DATA_W    (8),
    .SEG_W     (8),
    .OPEN_DATA (8'hFF)
  ) dut (
    .clk_sys_i    (clk),
    .reset_n_i    (reset_n),
    .model_i      (model),
    .ram_size_i   (ram_size),
    .ipc_ram_en_i (ipc),
    .m_req_i      (m_req),
    .m_we_i       (m_we),
    .m_seg_i      (m_seg),
    .m_addr_i     (m_addr),
    .m_wdata_i    (m_wdata),
    .m_ack_o      (m_ack),
    .m_rdata_o    (m_rdata),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_region_o (mem_region),
    .mem_wdata_o  (mem_wdata),
    .mem_ack_i    (mem_ack),
    .mem_rdata_i  (mem_rdata)
  );

  typedef struct {
    int unsigned master;
    logic [7:0]  rdata;
    logic [23:0] addr;
    region_t     rgn;
    bit          mem;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned issue_cyc = 0;
  bit          saw_mem = 0;
  bit          mem_hold = 0;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  last_wdata = 8'h00;
  logic        last_we = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Memory model: one-cycle acknowledge, data chosen by the stimulus.
  always @(negedge clk) begin
    if (mem_req && !mem_ack && !mem_hold) begin
      mem_ack    = 1'b1;
      mem_rdata  = mem_data;
      last_wdata = mem_wdata;
      last_we    = mem_we;
    end else begin
      mem_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mem_req) saw_mem = 1'b1;
    if (m_ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(m_ack), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("ack_master", 32'(m_ack), 32'(1 << e.master));
        chk("rdata", 32'(m_rdata[e.master*8 +: 8]), 32'(e.rdata));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("region", 32'(mem_region), 32'(e.rgn));
        chk("mem_req_seen", 32'(saw_mem), 32'(e.mem));
        if (e.lat >= 0) chk("latency", cyc - issue_cyc, 32'(e.lat));
      end
      saw_mem = 1'b0;
    end
  end

  task automatic push(int unsigned mi, logic [7:0] erd, logic [23:0] ea, region_t erg,
                      bit emem, int elat);
    exp_t e;
    e.master = mi;
    e.rdata  = erd;
    e.addr   = ea;
    e.rgn    = erg;
    e.mem    = emem;
    e.lat    = elat;
    sb.push_back(e);
  endtask

  task automatic wait_ack(int unsigned mi, int n, bit drop);
    int got = 0;
    int budget = 300;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (m_ack[mi]) got++;
    end
    chk("ack_arrived", 32'(got), 32'(n));
    if (drop) m_req[mi] = 1'b0;
  endtask

  task automatic wait_any(int n);
    int got = 0;
    int budget = 300;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (m_ack != '0) got++;
    end
    chk("acks_arrived", 32'(got), 32'(n));
  endtask

  task automatic xfer(int unsigned mi, bit we, logic [7:0] seg, logic [15:0] a, logic [7:0] wd,
                      logic [7:0] erd, region_t erg, bit emem, int elat);
    push(mi, erd, {seg, a}, erg, emem, elat);
    @(negedge clk);
    m_we[mi]            = we;
    m_seg[mi*8 +: 8]    = seg;
    m_addr[mi*16 +: 16] = a;
    m_wdata[mi*8 +: 8]  = wd;
    m_req[mi]           = 1'b1;
    issue_cyc           = cyc;
    wait_ack(mi, 1, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n  = 1'b0;
    model    = 1'b0;
    ram_size = 2'd0;
    ipc      = 1'b0;
    m_req    = '0;
    m_we     = '0;
    m_seg    = '0;
    m_addr   = '0;
    m_wdata  = '0;
    mem_ack  = 1'b0;
    mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_region", 32'(mem_region), 32'(RGN_OPEN));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_m_ack", 32'(m_ack), 32'h0);
    chk("rst_m_rdata", 32'(m_rdata), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      @(negedge clk);
    end

    mem_data = 8'h5A;
    xfer(1, 0, 8'h00, 16'h1234, 8'h00, 8'h5A, RGN_RAM, 1, 4);
    model = 1'b1;
    xfer(2, 0, 8'h00, 16'h0010, 8'h00, 8'hFF, RGN_OPEN, 0, 3);
    xfer(2, 0, 8'h0F, 16'h0900, 8'h00, 8'hFF, RGN_OPEN, 0, 3);
    ipc = 1'b1;
    mem_data = 8'h3C;
    xfer(2, 0, 8'h0F, 16'h0900, 8'h00, 8'h3C, RGN_RAM, 1, 4);
    repeat (3) @(negedge clk);
    chk("m1_rdata_held", 32'(m_rdata[8 +: 8]), 32'h5A);

    xfer(1, 1, 8'h0F, 16'hE000, 8'h77, 8'h5A, RGN_ROM, 0, 3);
    mem_data = 8'hEE;
    xfer(2, 1, 8'h0F, 16'hD800, 8'h99, 8'h3C, RGN_IO, 1, 4);
    chk("io_write_data", 32'(last_wdata), 32'h99);
    chk("io_write_we", 32'(last_we), 32'h1);
    xfer(1, 0, 8'h0F, 16'hD500, 8'h00, 8'hFF, RGN_OPEN, 0, 3);
    model = 1'b0;
    mem_data = 8'h42;
    xfer(1, 0, 8'h0F, 16'hD500, 8'h00, 8'h42, RGN_RAM, 1, 4);
    model = 1'b1;
    ram_size = 2'd1;
    mem_data = 8'h24;
    xfer(2, 0, 8'h04, 16'h0000, 8'h00, 8'h24, RGN_RAM, 1, 4);
    xfer(1, 0, 8'h00, 16'h0000, 8'h00, 8'hFF, RGN_OPEN, 0, 3);
    mem_data = 8'hE7;
    xfer(0, 0, 8'h0F, 16'h9000, 8'h00, 8'hE7, RGN_ROM, 1, 4);

    // Arbitration from a fresh reset so the round-robin pointer starts at master 1.
    @(negedge clk);
    reset_n = 1'b0;
    saw_mem = 1'b0;
    model = 1'b0;
    ram_size = 2'd0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mem_data = 8'hC3;
    m_we = '0;
    m_seg = '0;
    m_addr = {16'h0300, 16'h0200, 16'h0100};
    for (int i = 0; i < 4; i++) push(0, 8'hC3, 24'h000100, RGN_RAM, 1, -1);
    for (int i = 0; i < 2; i++) begin
      push(1, 8'hC3, 24'h000200, RGN_RAM, 1, -1);
      push(2, 8'hC3, 24'h000300, RGN_RAM, 1, -1);
    end
    @(negedge clk);
    m_req = 3'b111;
    wait_ack(0, 4, 1'b1);
    wait_any(4);
    m_req = '0;

    // Reset while the memory is still holding off its acknowledge.
    @(negedge clk);
    mem_hold = 1'b1;
    m_we[1] = 1'b0;
    m_seg[8 +: 8] = 8'h00;
    m_addr[16 +: 16] = 16'h0040;
    m_req[1] = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_mem_req_rose", 32'(mem_req), 32'h1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("mid_mem_req_async_drop", 32'(mem_req), 32'h0);
    m_req = '0;
    mem_hold = 1'b0;
    saw_mem = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_no_ack", 32'(m_ack), 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_mem_req", 32'(mem_req), 32'h0);
    chk("post_rst_rdata", 32'(m_rdata), 32'h0);
    mem_data = 8'h81;
    xfer(2, 0, 8'h01, 16'h4000, 8'h00, 8'h81, RGN_RAM, 1, 4);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cbm2_bus_arbiter.md
# cbm2_bus_arbiter

Parametrised multi-master bus arbiter and segment decoder for the CBM-II core, one generation beyond the single-CPU/VIC bus logic. It serialises up to MASTERS requesters (video fetch, CPU, DMA/co-processor) onto one shared 24-bit system memory port. It classifies each access by segment and model into RAM, ROM, I/O or open bus, and keeps per-master latched read data so a stalled master always sees stable data.

## Interface
- MASTERS, 3: requester count, 2..8; master 0 is video and has fixed top priority.
- DATA_W, 8: data width.
- SEG_W, 8: segment field width; address is {seg, addr[15:0]}.
- OPEN_DATA, 8'hFF: read value returned for open-bus accesses.
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- model  in  1  0=Professional, 1=Business.
- ram_size  in  2  0=128k, 1=256k, 2=1M, 3=16M.
- ipc_ram_en  in  1  enables seg 15 $0800-$0FFF RAM.
- m_req  in  MASTERS  per-master request, held high until m_ack.
- m_we  in  MASTERS  per-master write enable, sampled with m_req.
- m_seg  in  MASTERS*SEG_W  segment per master.
- m_addr  in  MASTERS*16  offset per master.
- m_wdata  in  MASTERS*DATA_W  write data per master.
- m_ack  out  MASTERS  one-cycle completion pulse.
- m_rdata  out  MASTERS*DATA_W  latched read data per master.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  SEG_W+16  system address.
- mem_region  out  2  region_t of the current access.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  memory completion pulse.
- mem_rdata  in  DATA_W  read data, valid with mem_ack.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any m_req is high, pick a winner. Master 0 wins if requesting. Otherwise round-robin over masters 1..MASTERS-1, starting after the last granted master. Capture the winner's seg, addr, we and wdata into the command register, decode the region, then go to ISSUE.
- Region decode for seg 15:
  - $0xxx is RAM if addr[11]=0 or ipc_ram_en; otherwise OPEN.
  - $8000-$CFFF and $E000-$FFFF are ROM.
  - $D000-$D3FF is RAM.
  - $D400-$D7FF is RAM if model=0; otherwise OPEN.
  - $D800-$DFFF is IO.
  - All other seg 15 space is OPEN.
- Region decode for other segments is RAM when:
  - ram_size=0: seg<=1 (P) or 1<=seg<=2 (B).
  - ram_size=1: seg<=3 (P) or 1<=seg<=4 (B).
  - ram_size 2 or 3: always.
  - Otherwise OPEN.
- ISSUE: assert mem_req, except for OPEN accesses and ROM writes, which skip to DONE. Then go to WAIT.
- WAIT: hold mem_req and the command until mem_ack. On mem_ack, drop mem_req and, for a read, latch mem_rdata into the winner's rdata register. Go to DONE.
- DONE: pulse m_ack[winner] for one cycle. For an OPEN read, load OPEN_DATA into the winner's rdata register. Update the round-robin pointer for masters 1+ only. Return to IDLE.
- m_rdata[i] holds its value until master i's next read completes; writes never change it.
- A master deasserting m_req mid-transfer is a protocol error. The transfer still completes and the ack is still issued.

## Timing
- Reset values:
  - FSM in IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_region=RGN_OPEN, mem_wdata=0.
  - m_ack all 0, m_rdata all 0.
  - Round-robin pointer at master 1.
- Reset asserted mid-transfer drops mem_req immediately (async) and abandons the transfer; no m_ack is issued.
- Latency from m_req rising in IDLE, with mem_ack in the first WAIT cycle:
  - Memory access: m_ack 4 cycles later.
  - OPEN access or ROM write: 3 cycles (no mem_req).
- m_rdata is valid in the same cycle as m_ack.
- mem_ack arriving in ISSUE is ignored; memory must acknowledge no earlier than one cycle after mem_req rises.
- A master may re-request in the cycle after its m_ack; it is arbitrated normally.

## Structure
- Package cbm2_bus_pkg holds:
  - region_t enum: RGN_RAM=0, RGN_ROM=1, RGN_IO=2, RGN_OPEN=3.
  - fsm state enum.
  - Seg 15 address constants.
- Sub-module cbm2_seg_decode: purely combinational (model, ram_size, ipc_ram_en, seg, addr) -> region_t. Shared with future I/O chip-select logic.

## Test plan
- Reset: hold reset_n low, release -> all outputs at reset values; mem_req=0 until a request arrives.
- Basic read: model=0, ram_size=0, master 1 reads seg 0 $1234; mem_ack with rdata=8'h5A one cycle after mem_req -> mem_addr=24'h001234, region RAM, m_ack[1] pulse, m_rdata[1]=8'h5A held until the next master-1 read.
- Open-bus decode, three accesses:
  - model=1, ram_size=0, seg 0 read -> no mem_req, m_rdata=8'hFF after 3 cycles.
  - Seg 15 $0900 with ipc_ram_en=0 -> OPEN.
  - Seg 15 $0900 with ipc_ram_en=1 -> RAM.
- Arbitration: masters 0, 1 and 2 all requesting continuously -> master 0 is served every transaction; drop master 0 -> masters 1 and 2 alternate.
- ROM write: seg 15 $E000 write -> region ROM, no mem_req, m_ack after 3 cycles, m_rdata unchanged.
- Reset mid-transfer: assert reset_n low during WAIT -> mem_req falls without waiting for a clock; no m_ack; FSM idle after release.
